matrix_streamer: RTL
====================

MATRIX_STREAMER -- requirements
Module: matrix_streamer

Interface
REQ-001 SHALL have parameter width_p, default 32, data word width.
REQ-002 SHALL have parameter array_width_p, default 2, array columns; array_height_p, default 2, array rows.
REQ-003 SHALL have parameter depth_p, default 2, number of input steps (inner dimension).
REQ-004 Derived constants: words_per_step = array_width_p+array_height_p; num_words = depth_p*words_per_step; num_results = array_width_p*array_height_p.
REQ-005 Clocking SHALL be one clock; reset is synchronous and active-high; ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
en_i  in  1  global enable; all registers except operand buffer hold when 0
load_v_i  in  1  operand buffer write strobe
load_addr_i  in  clog2(num_words)  operand write address
load_data_i  in  width_p  operand write data
start_i  in  1  begin one stream/flush/collect run
busy_o  out  1  run in progress
done_o  out  1  one-cycle run-complete pulse
arr_valid_o  out  1  operand word valid toward array driver
arr_ready_i  in  1  array driver ready
arr_data_o  out  width_p  operand word
arr_flush_o  out  1  flush request toward array driver
res_valid_i  in  1  result word valid from array driver
res_data_i  in  width_p  result word
res_yumi_o  out  1  result word consumed
rd_addr_i  in  clog2(num_results)  result read address
rd_data_o  out  width_p  result word at rd_addr_i, combinational

Function
REQ-006 FSM SHALL be one-hot with states IDLE, SEND, SETTLE, FLUSH, COLLECT, DONE; transitions only when en_i=1.
REQ-007 IDLE: start_i=1 -> SEND; word pointer cleared to 0.
REQ-008 SEND: arr_valid_o=1, arr_data_o=buffer[ptr]; transfer when arr_valid_o & arr_ready_i & en_i; ptr increments per transfer.
REQ-009 Transfer with ptr==num_words-1 -> SETTLE; arr_valid_o=0 outside SEND.
REQ-010 Words SHALL be sent in ascending address order, words_per_step consecutive words per step, one word per transfer, no gaps inserted by this block.
REQ-011 SETTLE: SHALL remain at least 2 enabled cycles and until arr_ready_i=1 -> FLUSH.
REQ-012 FLUSH: arr_flush_o=1 for exactly one enabled cycle, arr_valid_o=0 -> COLLECT; result index cleared to 0.
REQ-013 COLLECT: res_yumi_o = res_valid_i & en_i; each yumi writes res_data_i to result[idx], idx increments.
REQ-014 yumi with idx==num_results-1 -> DONE.
REQ-015 DONE: done_o=1 for one cycle -> IDLE.
REQ-016 res_yumi_o SHALL be 0 outside COLLECT; res_valid_i outside COLLECT is ignored.
REQ-017 busy_o = (state != IDLE).
REQ-018 load_v_i SHALL write buffer[load_addr_i] only in IDLE; ignored otherwise or when load_addr_i >= num_words; writes independent of en_i.
REQ-019 load_v_i and start_i in same IDLE cycle: write completes, streaming reads updated value.
REQ-020 start_i outside IDLE SHALL be ignored.
REQ-021 rd_data_o SHALL reflect result registers at all times; rd_addr_i >= num_results returns 0.
REQ-022 arr_ready_i deasserting mid-SEND stalls; ptr and arr_data_o held.

Reset
REQ-023 reset_i SHALL force IDLE, ptr=0, idx=0, all result registers 0, and all outputs 0 (rd_data_o=0) next cycle.
REQ-024 reset_i mid-run SHALL abort without asserting done_o; operand buffer contents unaffected.
REQ-025 reset_i SHALL take priority over en_i, start_i, and load_v_i.

Verification
REQ-026 Load words 1..8 at addresses 0..7, pulse start_i, arr_ready_i=1 -> arr_data_o 1..8 on 8 consecutive cycles, then arr_flush_o pulses once.
REQ-027 Toggle arr_ready_i low every other cycle during SEND -> same 8 words in order, none duplicated or dropped.
REQ-028 In COLLECT, drive res_valid_i with 10,20,30,40 separated by idle cycles -> rd_data_o at addresses 0..3 = 10,20,30,40, done_o one pulse, busy_o=0 after.
REQ-029 Assert reset_i after 3 words sent -> IDLE next cycle, busy_o=0, no done_o; restart resends buffer from word 1.
REQ-030 Hold en_i=0 for 5 cycles mid-SEND -> no transfers, state and ptr frozen; resume completes normally.
REQ-031 start_i during COLLECT and load_v_i during SEND -> both ignored; buffer and run unchanged.

Source files
------------

// File: rtl/matrix_streamer_if.sv
// Control, operand-stream and result-collect signals of matrix_streamer.
// slave is the streamer's view; master is the controller/array-driver side.
interface matrix_streamer_if #(
  parameter int unsigned width_p        = 32,
  parameter int unsigned array_width_p  = 2,
  parameter int unsigned array_height_p = 2,
  parameter int unsigned depth_p        = 2
);
  localparam int unsigned num_words   = depth_p * (array_width_p + array_height_p);
  localparam int unsigned num_results = array_width_p * array_height_p;
  localparam int unsigned load_addr_w = (num_words > 1) ? $clog2(num_words) : 1;
  localparam int unsigned rd_addr_w   = (num_results > 1) ? $clog2(num_results) : 1;

  logic                   en_i;
  logic                   load_v_i;
  logic [load_addr_w-1:0] load_addr_i;
  logic [width_p-1:0]     load_data_i;
  logic                   start_i;
  logic                   busy_o;
  logic                   done_o;
  logic                   arr_valid_o;
  logic                   arr_ready_i;
  logic [width_p-1:0]     arr_data_o;
  logic                   arr_flush_o;
  logic                   res_valid_i;
  logic [width_p-1:0]     res_data_i;
  logic                   res_yumi_o;
  logic [rd_addr_w-1:0]   rd_addr_i;
  logic [width_p-1:0]     rd_data_o;

  modport slave (
    input  en_i, load_v_i, load_addr_i, load_data_i, start_i,
           arr_ready_i, res_valid_i, res_data_i, rd_addr_i,
    output busy_o, done_o, arr_valid_o, arr_data_o, arr_flush_o,
           res_yumi_o, rd_data_o
  );

  modport master (
    output en_i, load_v_i, load_addr_i, load_data_i, start_i,
           arr_ready_i, res_valid_i, res_data_i, rd_addr_i,
    input  busy_o, done_o, arr_valid_o, arr_data_o, arr_flush_o,
           res_yumi_o, rd_data_o
  );
endinterface

// File: rtl/matrix_streamer.sv
// Streams a preloaded operand buffer into a systolic array driver, requests a
// flush, then collects the array's results into a readable register file.
module matrix_streamer #(
  parameter int unsigned width_p        = 32,
  parameter int unsigned array_width_p  = 2,
  parameter int unsigned array_height_p = 2,
  parameter int unsigned depth_p        = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  matrix_streamer_if.slave   ms_io
);
  localparam int unsigned words_per_step = array_width_p + array_height_p;
  localparam int unsigned num_words      = depth_p * words_per_step;
  localparam int unsigned num_results    = array_width_p * array_height_p;
  localparam int unsigned load_addr_w    = (num_words > 1) ? $clog2(num_words) : 1;
  localparam int unsigned rd_addr_w      = (num_results > 1) ? $clog2(num_results) : 1;

  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    SEND    = 6'b000010,
    SETTLE  = 6'b000100,
    FLUSH   = 6'b001000,
    COLLECT = 6'b010000,
    DONE    = 6'b100000
  } state_e;

  state_e                 state_q, state_d;
  logic [load_addr_w-1:0] ptr_q, ptr_d;
  logic [rd_addr_w-1:0]   idx_q, idx_d;
  logic                   settle_q, settle_d;
  logic [width_p-1:0]     opbuf_q  [num_words];
  logic [width_p-1:0]     result_q [num_results];
  logic                   xfer_c, yumi_c, load_c;

  assign xfer_c = (state_q == SEND) & ms_io.arr_ready_i & ms_io.en_i;
  assign yumi_c = (state_q == COLLECT) & ms_io.res_valid_i & ms_io.en_i;
  assign load_c = (state_q == IDLE) & ms_io.load_v_i
                & (32'(ms_io.load_addr_i) < num_words);

  // Control state; en_i gating is folded into the next-state logic.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      settle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
    end
  end

  // Operand buffer survives reset; reset only blocks a same-cycle write.
  always_ff @(posedge clk_i) begin
    if (!reset_i && load_c) begin
      opbuf_q[ms_io.load_addr_i] <= ms_io.load_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(num_results); i++) result_q[i] <= '0;
    end else if (yumi_c) begin
      result_q[idx_q] <= ms_io.res_data_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    if (ms_io.en_i) begin
      unique case (state_q)
        IDLE: begin
          if (ms_io.start_i) begin
            state_d = SEND;
            ptr_d   = '0;
          end
        end
        SEND: begin
          if (xfer_c) begin
            if (ptr_q == load_addr_w'(num_words - 1)) begin
              state_d  = SETTLE;
              ptr_d    = '0;
              settle_d = 1'b0;
            end else begin
              ptr_d = ptr_q + load_addr_w'(1);
            end
          end
        end
        // settle_q marks that the first settle cycle has already elapsed
        SETTLE: begin
          if (settle_q && ms_io.arr_ready_i) state_d = FLUSH;
          else                               settle_d = 1'b1;
        end
        FLUSH: begin
          state_d = COLLECT;
          idx_d   = '0;
        end
        COLLECT: begin
          if (yumi_c) begin
            if (idx_q == rd_addr_w'(num_results - 1)) state_d = DONE;
            else                                        idx_d = idx_q + rd_addr_w'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Pulses are qualified by en_i so each lasts exactly one enabled cycle.
  always_comb begin
    ms_io.busy_o      = (state_q != IDLE);
    ms_io.arr_valid_o = (state_q == SEND);
    ms_io.arr_data_o  = '0;
    ms_io.arr_flush_o = (state_q == FLUSH) & ms_io.en_i;
    ms_io.done_o      = (state_q == DONE) & ms_io.en_i;
    ms_io.res_yumi_o  = yumi_c;
    ms_io.rd_data_o   = '0;
    if (state_q == SEND) ms_io.arr_data_o = opbuf_q[ptr_q];
    if (32'(ms_io.rd_addr_i) < num_results) ms_io.rd_data_o = result_q[ms_io.rd_addr_i];
  end
endmodule
